expmul_sched: RTL
=================

# expmul_sched

Online-softmax sequencer in front of `expmul_stage`. Consumes one query row's stream of Q4.4 attention scores and tracks the running maximum. For each key it issues up to two ordered operations to the shared exp-multiply datapath: first rescale the O* accumulator by exp(m_old − m_new), then weight the key's V row by exp(s − m_new). At end of row it reports the final maximum and a done pulse.

## Interface
Parameters:
- `SEQ_LEN`, default `` `MAX_SEQ_LENGTH ``: keys per query row.
- `CNT_W`, default `$clog2(SEQ_LEN)`: key counter width.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `score_vld` in 1: score valid.
- `score_rdy` out 1: scheduler accepts a score.
- `score` in `EXPMUL_DIFF_IN_QT` (8, Q4.4 signed): attention score s_j.
- `em_vld` out 1: request to expmul (drives its `vld_in`).
- `em_rdy` in 1: expmul `rdy_out`.
- `em_a` out `EXPMUL_DIFF_IN_QT`: minuend.
- `em_b` out `EXPMUL_DIFF_IN_QT`: subtrahend (running max).
- `em_o_star_mode` out 1: 1 = rescale O*, 0 = weight V.
- `em_key_idx` out `CNT_W`: key index of the current op.
- `row_done` out 1: one-cycle pulse after the last key's V op handshakes.
- `max_out` out `EXPMUL_DIFF_IN_QT`: final row max, valid while `row_done`=1.

## Operation
- State register m (running max), s_q (latched score), key counter cnt, flag first.
- FSM states:
  - IDLE: `score_rdy`=1. On `score_vld`, latch s_q=score and m_old=m, set m=signed_max(m, score). Go to ISSUE_V if first, else ISSUE_O.
  - ISSUE_O: `em_vld`=1, `em_a`=m_old, `em_b`=m, `em_o_star_mode`=1. On `em_rdy`, go to ISSUE_V.
  - ISSUE_V: `em_vld`=1, `em_a`=s_q, `em_b`=m, `em_o_star_mode`=0.
    - On `em_rdy` with cnt==SEQ_LEN−1: go to DONE.
    - On `em_rdy` otherwise: cnt++, first=0, go to IDLE.
  - DONE: `row_done`=1, `max_out`=m. Next cycle: m=0x80, cnt=0, first=1, go to IDLE.
- Max comparison is signed two's-complement. Equal values keep m unchanged, so the O op carries a=b, which is exp(0)=1.0.
- First key of a row issues no O op, because the accumulator is empty.
- `em_a`, `em_b`, `em_o_star_mode` and `em_key_idx` are held stable while `em_vld`=1 and `em_rdy`=0.
- `em_vld` never drops without a handshake.
- No arithmetic beyond compare. Subtraction and widening happen inside expmul.

## Timing
- Reset values, after the first clock edge with `reset`=1:
  - state=IDLE, so `score_rdy`=1.
  - `em_vld`=0, `row_done`=0, `em_o_star_mode`=0.
  - `max_out`=m=0x80 (most negative Q4.4), cnt=0, first=1.
  - `em_a`=`em_b`=0, `em_key_idx`=0.
- Reset mid-row discards all state and any pending request. `em_vld` is 0 the cycle after reset.
- Throughput, with `em_rdy` held high:
  - Score accepted at cycle t.
  - O op presented t+1, V op t+2, next score accepted t+3.
  - First key: V op at t+1, next score accepted t+2.
- `row_done` asserts the cycle after the last V handshake. `score_rdy`=0 in DONE.
- `em_rdy` low stalls in the ISSUE states indefinitely with no state change.
- `score_rdy` is 0 outside IDLE, so `score_vld` there is ignored.
- Scores beyond SEQ_LEN per row are impossible. The counter wraps only via DONE.

## Structure
- Shared package / `sys_defs.svh`:
  - reuse `EXPMUL_DIFF_IN_QT`.
  - add `EXPSCHED_STATE_T` enum (IDLE, ISSUE_O, ISSUE_V, DONE).
  - add `` `EXPMUL_NEG_INF `` = 8'h80.
- One natural sub-module: `q_signed_max` (combinational signed max of two `EXPMUL_DIFF_IN_QT`), reusable by the max-tracking logic elsewhere.
- Outputs are registered from state. No combinational path from `em_rdy` to `em_vld`.

## Test plan
- SEQ_LEN=4, `em_rdy`=1, scores 0x10, 0x20, 0xF0, 0x20:
  - ops in order: V(0x10,0x10); O(0x10,0x20), V(0x20,0x20); O(0x20,0x20), V(0xF0,0x20); O(0x20,0x20), V(0x20,0x20).
  - then `row_done` with `max_out`=0x20.
- First-key rule: first score 0x80 gives no O op, V(0x80,0x80), and m stays 0x80.
- Backpressure: hold `em_rdy`=0 for 5 cycles in ISSUE_O. `em_vld` and all `em_*` fields stay constant, `score_rdy`=0, and the op completes on the `em_rdy` rising cycle.
- Reset asserted while in ISSUE_V on key 2. The next cycle has `em_vld`=0, `score_rdy`=1 and cnt=0, and the next score is treated as first (no O op).
- Two back-to-back rows: after `row_done`, the second row's first score 0xC0 yields V(0xC0,0xC0), confirming m was reset to 0x80 and not retained at the previous 0x20.
- Throughput check: with continuous `score_vld` and `em_rdy`, accepts occur at cycles 0, 2, 5, 8 for a 4-key row.

Source files
------------

// File: rtl/expmul_sched_pkg.sv
// expmul_sched_pkg
// Shared definitions for the online-softmax scheduler and the expmul
// datapath it feeds.
//   EXPMUL_DIFF_IN_QT : width of a Q4.4 signed score / difference operand
//   MAX_SEQ_LENGTH    : default number of keys per query row
//   EXPMUL_NEG_INF    : most negative Q4.4 value, start value of a running max
//   EXPSCHED_STATE_T  : scheduler FSM states
package expmul_sched_pkg;

  localparam int EXPMUL_DIFF_IN_QT = 8;
  localparam int MAX_SEQ_LENGTH    = 16;

  localparam logic [EXPMUL_DIFF_IN_QT-1:0] EXPMUL_NEG_INF = 8'h80;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_O = 2'd1,
    ISSUE_V = 2'd2,
    DONE    = 2'd3
  } EXPSCHED_STATE_T;

endpackage

// File: rtl/expmul_sched_q_signed_max.sv
// q_signed_max
// Combinational two's-complement maximum of two Q4.4 values.
//   a       in  : first operand (the incumbent; wins ties)
//   b       in  : second operand
//   max_val out : signed max(a, b)
module q_signed_max
  import expmul_sched_pkg::*;
(
  input  logic [EXPMUL_DIFF_IN_QT-1:0] a,
  input  logic [EXPMUL_DIFF_IN_QT-1:0] b,
  output logic [EXPMUL_DIFF_IN_QT-1:0] max_val
);

  // Ties return a, so a running max passed as a is never replaced by an equal score.
  always_comb begin
    max_val = ($signed(a) >= $signed(b)) ? a : b;
  end

endmodule

// File: rtl/expmul_sched.sv
// expmul_sched
// Online-softmax sequencer placed in front of the shared exp-multiply stage.
// It tracks the running row maximum m over a stream of Q4.4 scores. For every
// key it issues an O* rescale op exp(m_old - m_new) (skipped for the first
// key), followed by a V weighting op exp(s - m_new). At the end of the row it
// pulses row_done with the final max.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   score_vld/score_rdy  : score handshake, score = Q4.4 attention score
//   em_vld/em_rdy        : request handshake toward expmul
//   em_a, em_b           : minuend / subtrahend (em_b is always the running max)
//   em_o_star_mode       : 1 = rescale O*, 0 = weight V
//   em_key_idx           : key index of the presented op
//   row_done, max_out    : end-of-row pulse and the row's final max
module expmul_sched
  import expmul_sched_pkg::*;
#(
  parameter int SEQ_LEN = MAX_SEQ_LENGTH,
  parameter int CNT_W   = $clog2(SEQ_LEN)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         score_vld,
  output logic                         score_rdy,
  input  logic [EXPMUL_DIFF_IN_QT-1:0] score,
  output logic                         em_vld,
  input  logic                         em_rdy,
  output logic [EXPMUL_DIFF_IN_QT-1:0] em_a,
  output logic [EXPMUL_DIFF_IN_QT-1:0] em_b,
  output logic                         em_o_star_mode,
  output logic [CNT_W-1:0]             em_key_idx,
  output logic                         row_done,
  output logic [EXPMUL_DIFF_IN_QT-1:0] max_out
);

  localparam logic [CNT_W-1:0] LAST_KEY = CNT_W'(SEQ_LEN - 1);

  EXPSCHED_STATE_T              state;
  logic [EXPMUL_DIFF_IN_QT-1:0] m;
  logic [EXPMUL_DIFF_IN_QT-1:0] s_q;
  logic [CNT_W-1:0]             cnt;
  logic                         first;
  logic [EXPMUL_DIFF_IN_QT-1:0] m_new;

  // Candidate max if the presented score were accepted this cycle.
  q_signed_max u_max (
    .a       (m),
    .b       (score),
    .max_val (m_new)
  );

  // Single FSM. Every output is a register, updated on the transition that
  // enters the state presenting it. The old max needs no separate register
  // because em_a carries it for the whole ISSUE_O state, and em_rdy only
  // influences the next-state registers, never em_vld combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      m              <= EXPMUL_NEG_INF;
      s_q            <= '0;
      cnt            <= '0;
      first          <= 1'b1;
      score_rdy      <= 1'b1;
      em_vld         <= 1'b0;
      em_a           <= '0;
      em_b           <= '0;
      em_o_star_mode <= 1'b0;
      em_key_idx     <= '0;
      row_done       <= 1'b0;
      max_out        <= EXPMUL_NEG_INF;
    end else begin
      row_done <= 1'b0;
      case (state)
        IDLE: begin
          if (score_vld) begin
            s_q        <= score;
            m          <= m_new;
            score_rdy  <= 1'b0;
            em_vld     <= 1'b1;
            em_b       <= m_new;
            em_key_idx <= cnt;
            // The accumulator is empty on the first key, so there is nothing to rescale.
            if (first) begin
              state          <= ISSUE_V;
              em_a           <= score;
              em_o_star_mode <= 1'b0;
            end else begin
              state          <= ISSUE_O;
              em_a           <= m;
              em_o_star_mode <= 1'b1;
            end
          end
        end

        ISSUE_O: begin
          if (em_rdy) begin
            state          <= ISSUE_V;
            em_a           <= s_q;
            em_o_star_mode <= 1'b0;
          end
        end

        ISSUE_V: begin
          if (em_rdy) begin
            em_vld <= 1'b0;
            if (cnt == LAST_KEY) begin
              state    <= DONE;
              row_done <= 1'b1;
              max_out  <= m;
            end else begin
              state     <= IDLE;
              score_rdy <= 1'b1;
              cnt       <= cnt + CNT_W'(1);
              first     <= 1'b0;
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          score_rdy <= 1'b1;
          m         <= EXPMUL_NEG_INF;
          cnt       <= '0;
          first     <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
